// File: rtl/lzw_pkg.sv
// Shared LZW dictionary definitions: default widths, entry layout helpers and FSM encoding.
package lzw_pkg;

    localparam int unsigned LZW_CODE_W = 14;
    localparam int unsigned LZW_CHAR_W = 8;
    localparam int unsigned LZW_CNT_W  = 16;

    // Entry layout, LSB first: character, prefix code, valid flag.
    localparam int unsigned CHAR_LSB = 0;

    function automatic int unsigned prefix_lsb(input int unsigned char_w);
        return CHAR_LSB + char_w;
    endfunction

    function automatic int unsigned vld_bit(input int unsigned code_w, input int unsigned char_w);
        return prefix_lsb(char_w) + code_w;
    endfunction

    function automatic int unsigned entry_w(input int unsigned code_w, input int unsigned char_w);
        return vld_bit(code_w, char_w) + 1;
    endfunction

    localparam int unsigned ENTRY_W    = entry_w(LZW_CODE_W, LZW_CHAR_W);
    localparam int unsigned VLD_BIT    = vld_bit(LZW_CODE_W, LZW_CHAR_W);
    localparam int unsigned PREFIX_LSB = prefix_lsb(LZW_CHAR_W);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/lzw_dict_ram.sv
// Simple dual-port dictionary RAM: one write port, one read-first registered read port.
module lzw_dict_ram
    import lzw_pkg::*;
#(
    parameter int unsigned ADDR_W = LZW_CODE_W,
    parameter int unsigned DATA_W = entry_w(LZW_CODE_W, LZW_CHAR_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Same-address read and write in one cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lzw_dict_mirror.sv
// Receive-side LZW dictionary rebuilt from the tx sync-write stream, with clearing sweep,
// root-code synthesis, write-to-read bypass and saturating statistics.
module lzw_dict_mirror
    import lzw_pkg::*;
#(
    parameter  int unsigned CODE_W = LZW_CODE_W,
    parameter  int unsigned CHAR_W = LZW_CHAR_W,
    parameter  int unsigned CNT_W  = LZW_CNT_W,
    localparam int unsigned ENT_W  = entry_w(CODE_W, CHAR_W)
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rst,
    input  logic              I_state_clr,
    input  logic              I_dict_clr,
    input  logic [ENT_W-1:0]  I_dictionary_sync_data,
    input  logic [CODE_W-1:0] I_dictionary_sync_addr,
    input  logic              I_dictionary_sync_wren,
    input  logic              I_dictionary_rd_en,
    input  logic [CODE_W-1:0] I_dictionary_addr,
    output logic [ENT_W-1:0]  O_dictionary_dout,
    output logic              O_dictionary_rd_vld,
    output logic              O_dict_busy,
    output logic [CNT_W-1:0]  O_wr_cnt,
    output logic [CNT_W-1:0]  O_drop_cnt,
    output logic [CNT_W-1:0]  O_miss_cnt
);

    localparam int unsigned       DEPTH       = 2 ** CODE_W;
    localparam int unsigned       ROOT_CODES  = 2 ** CHAR_W;
    localparam int unsigned       VLD_POS     = vld_bit(CODE_W, CHAR_W);
    localparam logic [CODE_W-1:0] SWEEP_FIRST = CODE_W'(ROOT_CODES);
    localparam logic [CODE_W-1:0] SWEEP_LAST  = CODE_W'(DEPTH - 1);
    localparam logic [ENT_W-1:0]  VLD_MASK    = ENT_W'(1) << VLD_POS;

    state_t            state, state_nxt;
    logic [CODE_W-1:0] sweep_addr, sweep_addr_nxt;
    logic              sweeping;

    assign sweeping = (state == ST_SWEEP);

    // Sweep/run control
    always_comb begin
        state_nxt      = state;
        sweep_addr_nxt = sweep_addr;
        case (state)
            ST_SWEEP: begin
                if (I_dict_clr) begin
                    sweep_addr_nxt = SWEEP_FIRST;
                end else if (sweep_addr == SWEEP_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    sweep_addr_nxt = sweep_addr + CODE_W'(1);
                end
            end
            ST_RUN: begin
                if (I_dict_clr) begin
                    state_nxt      = ST_SWEEP;
                    sweep_addr_nxt = SWEEP_FIRST;
                end
            end
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            state       <= ST_SWEEP;
            sweep_addr  <= SWEEP_FIRST;
            O_dict_busy <= 1'b1;
        end else begin
            state       <= state_nxt;
            sweep_addr  <= sweep_addr_nxt;
            O_dict_busy <= (state_nxt == ST_SWEEP);
        end
    end

    // Write filter and single registered write stage
    logic              accept_c, drop_c;
    logic              w1_en;
    logic [CODE_W-1:0] w1_addr;
    logic [ENT_W-1:0]  w1_data;

    assign accept_c = I_dictionary_sync_wren && !sweeping && (I_dictionary_sync_addr >= SWEEP_FIRST);
    assign drop_c   = I_dictionary_sync_wren && !accept_c;

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            w1_en <= 1'b0;
        end else begin
            w1_en <= accept_c;
        end
    end

    always_ff @(posedge I_sys_clk) begin
        w1_addr <= I_dictionary_sync_addr;
        w1_data <= I_dictionary_sync_data | VLD_MASK;
    end

    // Sweep owns the write port whenever busy
    logic              ram_we_c;
    logic [CODE_W-1:0] ram_waddr_c;
    logic [ENT_W-1:0]  ram_wdata_c;
    logic [ENT_W-1:0]  ram_q;

    assign ram_we_c    = !I_sys_rst && (sweeping || w1_en);
    assign ram_waddr_c = sweeping ? sweep_addr : w1_addr;
    assign ram_wdata_c = sweeping ? '0 : w1_data;

    // Lookup pipeline: request register, RAM read plus bypass capture, output register
    logic              s1_vld, s1_sweep, s1_root;
    logic [CODE_W-1:0] s1_addr;
    logic              s2_vld, s2_sweep, s2_root, s2_byp;
    logic [CHAR_W-1:0] s2_char;
    logic [ENT_W-1:0]  s2_byp_data;

    lzw_dict_ram #(
        .ADDR_W (CODE_W),
        .DATA_W (ENT_W)
    ) u_ram (
        .clk   (I_sys_clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .raddr (s1_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= I_dictionary_rd_en;
            s2_vld <= s1_vld;
        end
    end

    // A write committing on the same edge as the RAM read is invisible to the read-first port.
    always_ff @(posedge I_sys_clk) begin
        s1_addr     <= I_dictionary_addr;
        s1_sweep    <= sweeping;
        s1_root     <= (I_dictionary_addr < SWEEP_FIRST);
        s2_sweep    <= s1_sweep;
        s2_root     <= s1_root;
        s2_char     <= s1_addr[CHAR_W-1:0];
        s2_byp      <= w1_en && (w1_addr == s1_addr);
        s2_byp_data <= w1_data;
    end

    logic [ENT_W-1:0] result_c;
    logic             miss_c;

    always_comb begin
        result_c = ram_q;
        if (s2_sweep) begin
            result_c = '0;
        end else if (s2_root) begin
            result_c = {1'b1, CODE_W'(0), s2_char};
        end else if (s2_byp) begin
            result_c = s2_byp_data;
        end
    end

    assign miss_c = s2_vld && !result_c[VLD_POS];

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            O_dictionary_rd_vld <= 1'b0;
            O_dictionary_dout   <= '0;
        end else begin
            O_dictionary_rd_vld <= s2_vld;
            if (s2_vld) begin
                O_dictionary_dout <= result_c;
            end
        end
    end

    // Saturating statistics; a clear overrides a coincident increment
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
        if (clr) begin
            return '0;
        end
        if (inc && (cnt != '1)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            O_wr_cnt   <= '0;
            O_drop_cnt <= '0;
            O_miss_cnt <= '0;
        end else begin
            O_wr_cnt   <= cnt_next(O_wr_cnt, accept_c, I_state_clr);
            O_drop_cnt <= cnt_next(O_drop_cnt, drop_c, I_state_clr);
            O_miss_cnt <= cnt_next(O_miss_cnt, miss_c, I_state_clr);
        end
    end

endmodule
